rsp_xbar: RTL and testbench
===========================

RSP_XBAR -- requirements
Module: rsp_xbar

Interface
REQ-001 SHALL have parameter NUM_INPUT, default 4, number of requesting input ports.
REQ-002 SHALL have parameter NUM_OUTPUT, default 4, number of destination output ports.
REQ-003 SHALL have parameter DATA_WIDTH, default 4, payload width per port.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port arst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port input_vector_i  input  NUM_INPUT x DATA_WIDTH  per-input payload.
REQ-007 SHALL have port input_dest_i  input  NUM_INPUT x $clog2(NUM_OUTPUT)  per-input destination index.
REQ-008 SHALL have port input_valid_i  input  NUM_INPUT  per-input payload valid.
REQ-009 SHALL have port input_ready_o  output  NUM_INPUT  per-input accept; transfer when valid and ready are both high.
REQ-010 SHALL have port output_vector_o  output  NUM_OUTPUT x DATA_WIDTH  registered payload per output.
REQ-011 SHALL have port output_src_o  output  NUM_OUTPUT x $clog2(NUM_INPUT)  index of the input that supplied the held payload.
REQ-012 SHALL have port output_valid_o  output  NUM_OUTPUT  output register occupied.
REQ-013 SHALL have port output_ready_i  input  NUM_OUTPUT  downstream accept.
REQ-014 SHALL have port dest_err_o  output  1  single-cycle pulse when an out-of-range destination is dropped.

Function
REQ-015 Each output SHALL own one payload register (data, src, valid); latency from input handshake to output_valid_o SHALL be exactly 1 cycle.
REQ-016 Output j SHALL be free in a cycle when output_valid_o[j]=0 or output_ready_i[j]=1; only a free output SHALL accept a new payload.
REQ-017 Each output SHALL run an independent round-robin arbiter over inputs with input_valid_i=1 and input_dest_i==j; at most one grant per output per cycle.
REQ-018 After granting input k, output j's highest priority SHALL move to (k+1) mod NUM_INPUT; with no grant the pointer SHALL hold.
REQ-019 input_ready_o[i] SHALL be combinational: high only when input i is granted by its free destination, or its destination is out of range.
REQ-020 input_ready_o[i] SHALL NOT depend on input_valid_i[i] being low.
REQ-021 An input with input_dest_i >= NUM_OUTPUT SHALL be accepted and discarded; dest_err_o SHALL be high the next cycle (registered OR over inputs).
REQ-022 Simultaneous output pop (valid and ready) and refill SHALL yield full throughput: one payload per output per cycle.
REQ-023 A free output with no grant SHALL clear output_valid_o[j] next cycle; a non-free output SHALL hold data and src stable.
REQ-024 Inputs SHALL be independent: a stall on one output SHALL NOT block inputs targeting other outputs.

Reset
REQ-025 While arst_i is high, output_valid_o SHALL be 0, output_vector_o 0, output_src_o 0, dest_err_o 0, all arbiter pointers 0.
REQ-026 Reset assertion mid-transfer SHALL drop held payloads immediately without waiting for a clock edge.
REQ-027 input_ready_o SHALL be 0 while arst_i is high.

Configuration
REQ-028 Macro RSP_XBAR_STATS_EN SHALL, when defined, add output port xfer_count_o  NUM_OUTPUT x 32 counting completed output handshakes per output, reset to 0, wrapping at 2^32.
REQ-029 Without RSP_XBAR_STATS_EN the port and counters SHALL be absent and all other behaviour identical.

Verification (NUM_INPUT=4, NUM_OUTPUT=4, DATA_WIDTH=4)
REQ-030 Single route: input 2 valid, data 0xA, dest 1, output_ready_i=1111 -> next cycle output_valid_o[1]=1, output_vector_o[1]=0xA, output_src_o[1]=2.
REQ-031 Contention: inputs 0,1,3 all dest 2 held valid, output_ready_i[2]=1 -> output 2 delivers src order 0,1,3,0 on consecutive cycles.
REQ-032 Backpressure: output_ready_i[0]=0 with output 0 full -> input_ready_o to dest 0 stays 0, output_vector_o[0] stable; release -> one transfer per cycle resumes.
REQ-033 Parallel: inputs 0..3 dest 3,2,1,0 simultaneously -> all four input_ready_o=1 same cycle, each output holds matching src next cycle.
REQ-034 Reset mid-stream: assert arst_i between edges with all outputs full -> output_valid_o=0000 immediately; after release first grant on output 0 goes to input 0.
REQ-035 Random: 10000 cycles random valid/dest/ready -> every output payload equals its recorded input payload, in per-input order, none lost or duplicated; with RSP_XBAR_STATS_EN counts match scoreboard.

Source files
------------

// File: rtl/rsp_xbar.sv
// Response crossbar: per-output round-robin arbiters feeding one-deep output registers.
// Optional RSP_XBAR_STATS_EN adds per-output handshake counters on xfer_count_o.
module rsp_xbar #(
  parameter int NUM_INPUT  = 4,
  parameter int NUM_OUTPUT = 4,
  parameter int DATA_WIDTH = 4,
  localparam int DW = (NUM_OUTPUT > 1) ? $clog2(NUM_OUTPUT) : 1,
  localparam int SW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  arst_i,
  input  logic [NUM_INPUT-1:0][DATA_WIDTH-1:0]  input_vector_i,
  input  logic [NUM_INPUT-1:0][DW-1:0]          input_dest_i,
  input  logic [NUM_INPUT-1:0]                  input_valid_i,
  output logic [NUM_INPUT-1:0]                  input_ready_o,
  output logic [NUM_OUTPUT-1:0][DATA_WIDTH-1:0] output_vector_o,
  output logic [NUM_OUTPUT-1:0][SW-1:0]         output_src_o,
  output logic [NUM_OUTPUT-1:0]                 output_valid_o,
  input  logic [NUM_OUTPUT-1:0]                 output_ready_i,
`ifdef RSP_XBAR_STATS_EN
  output logic [NUM_OUTPUT-1:0][31:0]           xfer_count_o,
`endif
  output logic                                  dest_err_o
);

  localparam logic [DW:0] NOUT = (DW+1)'(NUM_OUTPUT);

  logic [NUM_INPUT-1:0]                 oor;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] req;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] gnt;
  logic [NUM_OUTPUT-1:0]                found;
  logic [NUM_OUTPUT-1:0]                free;
  logic [NUM_OUTPUT-1:0][SW-1:0]        ptr;
  logic [NUM_OUTPUT-1:0][SW-1:0]        win;
  logic                                 err_d;

  always_comb begin
    oor   = '0;
    req   = '0;
    err_d = 1'b0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      oor[i] = ({1'b0, input_dest_i[i]} >= NOUT);
      err_d  = err_d | (input_valid_i[i] & oor[i]);
      for (int j = 0; j < NUM_OUTPUT; j++) begin
        req[j][i] = input_valid_i[i] && !oor[i] &&
                    (input_dest_i[i] == DW'(j));
      end
    end
  end

  always_comb begin
    free = ~output_valid_o | output_ready_i;
  end

  // Search starts at the pointer and wraps, so the first hit is the RR winner
  always_comb begin
    found = '0;
    win   = '0;
    gnt   = '0;
    for (int j = 0; j < NUM_OUTPUT; j++) begin
      for (int off = 0; off < NUM_INPUT; off++) begin
        int idx;
        idx = (int'(ptr[j]) + off) % NUM_INPUT;
        if (!found[j] && req[j][idx]) begin
          found[j] = 1'b1;
          win[j]   = SW'(idx);
        end
      end
      gnt[j][win[j]] = found[j] & free[j];
    end
  end

  always_comb begin
    input_ready_o = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      logic rdy;
      rdy = oor[i];
      for (int j = 0; j < NUM_OUTPUT; j++) begin
        rdy = rdy | gnt[j][i];
      end
      input_ready_o[i] = rdy & ~arst_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      output_valid_o  <= '0;
      output_vector_o <= '0;
      output_src_o    <= '0;
      ptr             <= '0;
      dest_err_o      <= 1'b0;
    end else begin
      dest_err_o <= err_d;
      for (int j = 0; j < NUM_OUTPUT; j++) begin
        if (free[j]) begin
          output_valid_o[j] <= found[j];
          if (found[j]) begin
            output_vector_o[j] <= input_vector_i[win[j]];
            output_src_o[j]    <= win[j];
            ptr[j] <= SW'((int'(win[j]) + 1) % NUM_INPUT);
          end
        end
      end
    end
  end

`ifdef RSP_XBAR_STATS_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      xfer_count_o <= '0;
    end else begin
      for (int j = 0; j < NUM_OUTPUT; j++) begin
        if (output_valid_o[j] && output_ready_i[j]) begin
          xfer_count_o[j] <= xfer_count_o[j] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_rsp_xbar.sv
// Directed vector table plus random scoreboard run for rsp_xbar (4x4, 4-bit data).
module tb_rsp_xbar;

  logic            clk;
  logic            arst;
  logic [3:0][3:0] in_vec;
  logic [3:0][1:0] in_dest;
  logic [3:0]      in_valid;
  logic [3:0]      in_ready;
  logic [3:0][3:0] out_vec;
  logic [3:0][1:0] out_src;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready;
  logic            derr;
`ifdef RSP_XBAR_STATS_EN
  logic [3:0][31:0] xcnt;
`endif

  int tests = 0;
  int fails = 0;

  rsp_xbar #(
    .NUM_INPUT(4),
    .NUM_OUTPUT(4),
    .DATA_WIDTH(4)
  ) dut (
    .clk_i(clk),
    .arst_i(arst),
    .input_vector_i(in_vec),
    .input_dest_i(in_dest),
    .input_valid_i(in_valid),
    .input_ready_o(in_ready),
    .output_vector_o(out_vec),
    .output_src_o(out_src),
    .output_valid_o(out_valid),
    .output_ready_i(out_ready),
`ifdef RSP_XBAR_STATS_EN
    .xfer_count_o(xcnt),
`endif
    .dest_err_o(derr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  d;
    logic [15:0] x;
    logic [3:0]  ordy;
    logic [3:0]  irdy;
    logic [3:0]  ov;
    logic [15:0] vec;
    logic [7:0]  src;
  } vec_t;

  vec_t tv[12];
  logic [3:0] q[16][$];
  int npop[4];

  initial begin
    // single route, then contention on output 2, parallel, backpressure on 0
    tv[0]  = '{4'b0100, {2'd0,2'd1,2'd0,2'd0}, 16'h0A00, 4'hF,
               4'b0100, 4'b0010, 16'h00A0, {2'd0,2'd0,2'd2,2'd0}};
    tv[1]  = '{4'b1011, {2'd2,2'd0,2'd2,2'd2}, 16'h7065, 4'hF,
               4'b0001, 4'b0100, 16'h0500, {2'd0,2'd0,2'd0,2'd0}};
    tv[2]  = '{4'b1011, {2'd2,2'd0,2'd2,2'd2}, 16'h7065, 4'hF,
               4'b0010, 4'b0100, 16'h0600, {2'd0,2'd1,2'd0,2'd0}};
    tv[3]  = '{4'b1011, {2'd2,2'd0,2'd2,2'd2}, 16'h7065, 4'hF,
               4'b1000, 4'b0100, 16'h0700, {2'd0,2'd3,2'd0,2'd0}};
    tv[4]  = '{4'b1011, {2'd2,2'd0,2'd2,2'd2}, 16'h7065, 4'hF,
               4'b0001, 4'b0100, 16'h0500, {2'd0,2'd0,2'd0,2'd0}};
    tv[5]  = '{4'b1111, {2'd0,2'd1,2'd2,2'd3}, 16'h4321, 4'hF,
               4'b1111, 4'b1111, 16'h1234, {2'd0,2'd1,2'd2,2'd3}};
    tv[6]  = '{4'b0000, 8'h00, 16'h0000, 4'hF,
               4'b0000, 4'b0000, 16'h0000, 8'h00};
    tv[7]  = '{4'b0001, 8'h00, 16'h0009, 4'hF,
               4'b0001, 4'b0001, 16'h0009, 8'h00};
    tv[8]  = '{4'b0011, 8'h00, 16'h00B9, 4'b1110,
               4'b0000, 4'b0001, 16'h0009, 8'h00};
    tv[9]  = '{4'b0011, 8'h00, 16'h00B9, 4'b1110,
               4'b0000, 4'b0001, 16'h0009, 8'h00};
    tv[10] = '{4'b0011, 8'h00, 16'h00B9, 4'hF,
               4'b0010, 4'b0001, 16'h000B, {2'd0,2'd0,2'd0,2'd1}};
    tv[11] = '{4'b0011, 8'h00, 16'h00C9, 4'hF,
               4'b0001, 4'b0001, 16'h0009, 8'h00};

    arst      = 1'b1;
    in_vec    = '1;
    in_dest   = '0;
    in_valid  = 4'hF;
    out_ready = 4'hF;
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_vec", out_vec, 0);
    chk("rst_src", out_src, 0);
    chk("rst_derr", derr, 0);
    in_valid = '0;
    #2 arst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      in_valid  = tv[k].v;
      in_dest   = tv[k].d;
      in_vec    = tv[k].x;
      out_ready = tv[k].ordy;
      #1;
      chk($sformatf("v%0d_irdy", k), in_ready, tv[k].irdy);
      @(posedge clk); #1;
      chk($sformatf("v%0d_ov", k), out_valid, tv[k].ov);
      chk($sformatf("v%0d_derr", k), derr, 0);
      for (int j = 0; j < 4; j++) begin
        if (tv[k].ov[j]) begin
          chk($sformatf("v%0d_vec%0d", k, j), out_vec[j], tv[k].vec[j*4 +: 4]);
          chk($sformatf("v%0d_src%0d", k, j), out_src[j], tv[k].src[j*2 +: 2]);
        end
      end
    end

    // fill every output (input 1 -> output 0 moves its pointer to 2), then reset mid-cycle
    in_valid  = 4'hF;
    in_dest   = {2'd3, 2'd2, 2'd0, 2'd1};
    in_vec    = 16'h4321;
    out_ready = 4'hF;
    @(posedge clk); #1;
    chk("fill_ov", out_valid, 4'hF);
    in_valid  = '0;
    out_ready = '0;
    #3 arst = 1'b1;
    in_valid = 4'hF;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_vec", out_vec, 0);
    chk("mid_rst_irdy", in_ready, 0);
    #1 arst = 1'b0;
    in_dest   = '0;
    out_ready = 4'hF;
    #1;
    chk("post_rst_irdy", in_ready, 4'b0001);
    @(posedge clk); #1;
    chk("post_rst_ov", out_valid, 4'b0001);
    chk("post_rst_vec", out_vec[0], 4'h1);
    chk("post_rst_src", out_src[0], 0);

    // fresh reset so counters and scoreboard start together
    in_valid = '0;
    #2 arst = 1'b1;
    #2 arst = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) npop[j] = 0;

    for (int c = 0; c < 10030; c++) begin
      int pc[4];
      logic [3:0] reqd;
      if (c < 10000) begin
        in_valid = 4'($urandom);
        in_dest  = 8'($urandom);
        in_vec   = 16'($urandom);
        for (int j = 0; j < 4; j++) out_ready[j] = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = '0;
        out_ready = 4'hF;
      end
      #1;
      for (int j = 0; j < 4; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          int qi;
          qi = int'(out_src[j]) * 4 + j;
          npop[j]++;
          if (q[qi].size() == 0) begin
            chk($sformatf("pop_empty_o%0d", j), 1, 0);
          end else begin
            chk($sformatf("rand_data_o%0d", j), out_vec[j], q[qi].pop_front());
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        pc[j]   = 0;
        reqd[j] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i]) reqd[in_dest[i]] = 1'b1;
        if (in_valid[i] && in_ready[i]) begin
          q[i*4 + int'(in_dest[i])].push_back(in_vec[i]);
          pc[in_dest[i]]++;
        end
      end
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("grant_cnt_o%0d", j), pc[j],
            ((!out_valid[j] || out_ready[j]) && reqd[j]) ? 1 : 0);
      end
      @(posedge clk); #1;
    end

    chk("drain_ov", out_valid, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("leftover_%0d", k), q[k].size(), 0);
    end
`ifdef RSP_XBAR_STATS_EN
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("xfer_cnt_%0d", j), xcnt[j], npop[j]);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
